// File: rtl/key_pio_pkg.sv
// Shared constants for the key input PIO: register word addresses and edge-type encodings.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchroniser followed by a counter-based debouncer.
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             deb_p2;
    logic [CNT_W-1:0] cnt;

    // sync_p0/sync_p1: metastability chain; deb_p2: debounced state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            deb_p2  <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            if (sync_p1 == deb_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_p2 <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign q = deb_p2;

endmodule

// File: rtl/key_pio_in.sv
// Avalon-MM input PIO: debounced key/switch inputs, edge capture with W1C, maskable level irq.
module key_pio_in
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_p1;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .d      (in_port[i]),
            .q      (deb[i])
        );
    end

    assign wr_en     = chipselect && !write_n;
    assign rd_en     = chipselect && !read_n;
    assign unused_wd = ^writedata;

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det = deb & ~deb_p1;
            EDGE_FALLING: edge_det = ~deb & deb_p1;
            default:      edge_det = deb ^ deb_p1;
        endcase
    end

    always_comb begin
        edge_clr = '0;
        if (wr_en && address == ADDR_EDGE) edge_clr = writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = deb;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
            default:   rd_mux = '0;
        endcase
    end

    // A fresh edge overrides a same-cycle clear of that bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_p1       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            deb_p1       <= deb;
            edge_capture <= (edge_capture & ~edge_clr) | edge_det;
            irq          <= |(edge_capture & irq_mask);
            if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
            if (rd_en) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_key_pio_in.sv
// Directed bench for key_pio_in with WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_key_pio_in;

    localparam int WIDTH = 4;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             read_n     = 1'b1;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = 32'd0;
    logic [WIDTH-1:0] in_port    = '0;
    logic [31:0]      readdata;
    logic             irq;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    key_pio_in #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (1),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
        check_vec(tag, readdata, exp);
    endtask

    task automatic read_hold(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
    endtask

    task automatic read_release();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    initial begin
        // Reset with inputs high: they must not leak through while reset_n=0
        in_port = 4'hF;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check_vec("rst_irq", {31'd0, irq}, 32'd0);
        read_chk(2'd0, 32'h0, "rst_data");
        read_chk(2'd2, 32'h0, "rst_mask");
        read_chk(2'd3, 32'h0, "rst_edge");
        check_vec("rst_irq2", {31'd0, irq}, 32'd0);

        repeat (10) tick();
        read_chk(2'd0, 32'hF, "data_high");
        read_chk(2'd3, 32'h0, "rise_ignored");

        // Clean falling step on bit0: debounced value changes 6 edges later
        in_port = 4'hE;
        read_hold(2'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_vec($sformatf("drop_t%0d", k), readdata, (k < 7) ? 32'hF : 32'hE);
        end
        read_release();
        read_chk(2'd3, 32'h1, "edge_bit0");

        // Restore bit0, clear capture, then a 3-cycle glitch on bit1
        in_port = 4'hF;
        repeat (8) tick();
        bus_write(2'd3, 32'h1);
        read_chk(2'd3, 32'h0, "w1c_clear");
        in_port = 4'hD;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (8) tick();
        read_chk(2'd0, 32'hF, "glitch_data");
        read_chk(2'd3, 32'h0, "glitch_edge");

        // Mask bit0, falling edge: capture at edge 7, irq at edge 8
        bus_write(2'd2, 32'h1);
        read_chk(2'd2, 32'h1, "mask_rb");
        in_port = 4'hE;
        read_hold(2'd3);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_vec($sformatf("irq_t%0d", k), {31'd0, irq}, (k >= 8) ? 32'd1 : 32'd0);
            if (k == 7) check_vec("cap_t7", readdata, 32'h0);
            if (k == 8) check_vec("cap_t8", readdata, 32'h1);
        end
        read_release();
        bus_write(2'd3, 32'h1);
        check_vec("irq_w1c_edge", {31'd0, irq}, 32'd1);
        tick();
        check_vec("irq_w1c_next", {31'd0, irq}, 32'd0);
        read_chk(2'd3, 32'h0, "cap_after_w1c");

        // Bit1 captured 2 cycles before bit2; clear both as bit2 is captured
        in_port = 4'hC;
        tick();
        tick();
        in_port = 4'h8;
        repeat (6) tick();
        bus_write(2'd3, 32'h6);
        read_chk(2'd3, 32'h4, "set_wins");
        check_vec("irq_unmasked", {31'd0, irq}, 32'd0);

        // Build capture 0x3 with mask 0xF, then reset mid-debounce
        bus_write(2'd3, 32'h4);
        in_port = 4'hB;
        repeat (8) tick();
        in_port = 4'h8;
        repeat (8) tick();
        bus_write(2'd2, 32'hF);
        read_chk(2'd3, 32'h3, "pre_rst_cap");
        check_vec("pre_rst_irq", {31'd0, irq}, 32'd1);
        in_port = 4'h0;
        repeat (4) tick();
        reset_n = 1'b0;
        in_port = 4'hF;
        tick();
        reset_n = 1'b1;
        check_vec("mid_rst_irq", {31'd0, irq}, 32'd0);
        check_vec("mid_rst_rdata", readdata, 32'h0);
        read_hold(2'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_vec($sformatf("restart_t%0d", k), readdata, (k < 7) ? 32'h0 : 32'hF);
        end
        read_release();
        read_chk(2'd2, 32'h0, "post_rst_mask");
        read_chk(2'd3, 32'h0, "post_rst_edge");
        check_vec("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_pio_in.md
Name: key_pio_in

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the system's LED output PIO.
- Samples an external button/switch bus, synchronises and debounces it, and latches edge events.
- Raises a maskable level interrupt to the Nios II processor.
- Sits on the processor data master bus alongside the output PIOs.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised bit must differ from its debounced value before the debounced value changes (≥1).
- EDGE_TYPE, 1, 0=rising, 1=falling, 2=any edge of the debounced value sets edge capture.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, registered.
- irq  out  1  level interrupt request, registered.

Behaviour:
- Reset:
  - Synchronous only: applied on the clk edge while reset_n=0.
  - Clears synchroniser flops, debounced value, counters, irq_mask, edge_capture, readdata and irq.
  - Reset mid-debounce discards the count.
  - in_port is ignored while reset_n=0.
- Synchroniser:
  - Two flops per bit.
  - Synced value lags in_port by 2 cycles.
- Debounce (per bit):
  - When synced≠debounced, the counter increments.
  - When synced==debounced, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while synced≠debounced, the debounced value takes synced and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES therefore never propagate.
  - Total in_port→debounced latency for a clean step: 2+DEBOUNCE_CYCLES cycles.
- Edge detect:
  - Compares the debounced value with its one-cycle-delayed copy.
  - A qualifying edge per EDGE_TYPE sets edge_capture[i] on the following clk.
- Register map (word addresses):
  - 0 data: read-only debounced value, zero-extended; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 irq_mask: R/W, WIDTH bits; writedata[WIDTH-1:0] stored.
  - 3 edge_capture: read returns captured bits; write-1-to-clear per bit.
- Simultaneous events:
  - A new edge on bit i in the same cycle as a W1C of bit i leaves bit i set (set wins).
  - Other bits clear normally.
- Read timing:
  - readdata is registered and valid the cycle after chipselect && !read_n (read latency 1).
  - Holds its value otherwise.
  - Upper 32-WIDTH bits are always 0.
- Write timing: registers update on the clk edge where chipselect && !write_n.
- irq:
  - Registered: irq <= |(edge_capture & irq_mask), i.e. one cycle after the capture or mask change.
  - Deasserts one cycle after the last enabled bit clears.
- Reads have no side effects; edge_capture is not cleared by reading.
- Address decode ignores chipselect=0 entirely.

Decomposition:
- Shared package key_pio_pkg:
  - Register address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- Sub-module pio_debounce:
  - One bit: two-flop synchroniser, counter and debounced output.
  - Parameterised by DEBOUNCE_CYCLES and CNT_W.
  - Generated WIDTH times.
- The top level holds edge detect, registers, read mux and irq.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1):
- Reset, then read address 0, 2 and 3 -> readdata=0x0 each, one cycle after the read strobe; irq=0.
- Hold in_port=4'hF for 10 cycles, then drive bit0 low and hold -> data reads 0xF until 6 cycles after the drop, then 0xE; edge_capture reads 0x1.
- Pulse in_port[1] low for 3 cycles -> data stays 0xF; edge_capture stays 0x0 (glitch rejected).
- Write mask=0x1, then cause a bit0 falling edge -> irq=1 one cycle after edge_capture=0x1. Write 0x1 to address 3 -> edge_capture=0x0 and irq=0 the following cycle.
- Issue a W1C of 0x4 on the same cycle the bit2 falling edge is captured -> edge_capture bit2 remains 1.
- Assert reset_n=0 for 1 cycle mid-debounce (counter=2) with capture 0x3 and mask 0xF -> all registers 0 and irq=0 after that edge; debounce restarts from count 0.
